// File: rtl/logic_operand_stage.sv
// Operand-latch stage for the scalar logic unit: two-entry skid buffer with
// write-back forwarding applied on capture and to every held entry.
module logic_operand_stage #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_opA,
  input  logic [WIDTH-1:0] in_opB,
  input  logic [REGW-1:0]  in_rsA,
  input  logic [REGW-1:0]  in_rsB,
  input  logic [1:0]       in_op,
  input  logic [REGW-1:0]  in_dst,
  input  logic             fwd_valid,
  input  logic [REGW-1:0]  fwd_reg,
  input  logic [WIDTH-1:0] fwd_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_opA,
  output logic [WIDTH-1:0] out_opB,
  output logic [1:0]       out_op,
  output logic [REGW-1:0]  out_dst
);

  logic             main_valid, skid_valid;
  logic [WIDTH-1:0] main_opa, main_opb, skid_opa, skid_opb;
  logic [REGW-1:0]  main_rsa, main_rsb, skid_rsa, skid_rsb;
  logic [REGW-1:0]  main_dst, skid_dst;
  logic [1:0]       main_op, skid_op;

  logic             main_valid_nxt, skid_valid_nxt;
  logic [WIDTH-1:0] main_opa_nxt, main_opb_nxt, skid_opa_nxt, skid_opb_nxt;
  logic [REGW-1:0]  main_rsa_nxt, main_rsb_nxt, skid_rsa_nxt, skid_rsb_nxt;
  logic [REGW-1:0]  main_dst_nxt, skid_dst_nxt;
  logic [1:0]       main_op_nxt, skid_op_nxt;

  logic             fire, accept;
  logic [WIDTH-1:0] cap_opa, cap_opb;
  logic [WIDTH-1:0] main_opa_f, main_opb_f, skid_opa_f, skid_opb_f;

  // Register 0 means "no register" and must never pick up a forwarded value.
  function automatic logic fwd_hit(input logic [REGW-1:0] rs,
                                   input logic            fv,
                                   input logic [REGW-1:0] fr);
    return fv && (rs != '0) && (rs == fr);
  endfunction

  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign out_opA   = main_opa;
  assign out_opB   = main_opb;
  assign out_op    = main_op;
  assign out_dst   = main_dst;

  assign fire   = main_valid & out_ready;
  assign accept = in_valid & ~skid_valid;

  assign cap_opa    = fwd_hit(in_rsA,   fwd_valid, fwd_reg) ? fwd_data : in_opA;
  assign cap_opb    = fwd_hit(in_rsB,   fwd_valid, fwd_reg) ? fwd_data : in_opB;
  assign main_opa_f = fwd_hit(main_rsa, fwd_valid, fwd_reg) ? fwd_data : main_opa;
  assign main_opb_f = fwd_hit(main_rsb, fwd_valid, fwd_reg) ? fwd_data : main_opb;
  assign skid_opa_f = fwd_hit(skid_rsa, fwd_valid, fwd_reg) ? fwd_data : skid_opa;
  assign skid_opb_f = fwd_hit(skid_rsb, fwd_valid, fwd_reg) ? fwd_data : skid_opb;

  always_comb begin
    main_valid_nxt = main_valid;
    main_opa_nxt   = main_opa;
    main_opb_nxt   = main_opb;
    main_rsa_nxt   = main_rsa;
    main_rsb_nxt   = main_rsb;
    main_op_nxt    = main_op;
    main_dst_nxt   = main_dst;
    skid_valid_nxt = skid_valid;
    skid_opa_nxt   = skid_opa;
    skid_opb_nxt   = skid_opb;
    skid_rsa_nxt   = skid_rsa;
    skid_rsb_nxt   = skid_rsb;
    skid_op_nxt    = skid_op;
    skid_dst_nxt   = skid_dst;

    if (flush) begin
      main_valid_nxt = 1'b0;
      skid_valid_nxt = 1'b0;
    end else if (!main_valid || fire) begin
      // The departing main entry is not forwarded; only what remains is.
      if (skid_valid) begin
        main_valid_nxt = 1'b1;
        main_opa_nxt   = skid_opa_f;
        main_opb_nxt   = skid_opb_f;
        main_rsa_nxt   = skid_rsa;
        main_rsb_nxt   = skid_rsb;
        main_op_nxt    = skid_op;
        main_dst_nxt   = skid_dst;
        skid_valid_nxt = 1'b0;
      end else if (accept) begin
        main_valid_nxt = 1'b1;
        main_opa_nxt   = cap_opa;
        main_opb_nxt   = cap_opb;
        main_rsa_nxt   = in_rsA;
        main_rsb_nxt   = in_rsB;
        main_op_nxt    = in_op;
        main_dst_nxt   = in_dst;
      end else begin
        main_valid_nxt = 1'b0;
      end
    end else begin
      main_opa_nxt = main_opa_f;
      main_opb_nxt = main_opb_f;
      if (skid_valid) begin
        skid_opa_nxt = skid_opa_f;
        skid_opb_nxt = skid_opb_f;
      end else if (accept) begin
        skid_valid_nxt = 1'b1;
        skid_opa_nxt   = cap_opa;
        skid_opb_nxt   = cap_opb;
        skid_rsa_nxt   = in_rsA;
        skid_rsb_nxt   = in_rsB;
        skid_op_nxt    = in_op;
        skid_dst_nxt   = in_dst;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      main_valid <= 1'b0;
      main_opa   <= '0;
      main_opb   <= '0;
      main_rsa   <= '0;
      main_rsb   <= '0;
      main_op    <= '0;
      main_dst   <= '0;
      skid_valid <= 1'b0;
      skid_opa   <= '0;
      skid_opb   <= '0;
      skid_rsa   <= '0;
      skid_rsb   <= '0;
      skid_op    <= '0;
      skid_dst   <= '0;
    end else begin
      main_valid <= main_valid_nxt;
      main_opa   <= main_opa_nxt;
      main_opb   <= main_opb_nxt;
      main_rsa   <= main_rsa_nxt;
      main_rsb   <= main_rsb_nxt;
      main_op    <= main_op_nxt;
      main_dst   <= main_dst_nxt;
      skid_valid <= skid_valid_nxt;
      skid_opa   <= skid_opa_nxt;
      skid_opb   <= skid_opb_nxt;
      skid_rsa   <= skid_rsa_nxt;
      skid_rsb   <= skid_rsb_nxt;
      skid_op    <= skid_op_nxt;
      skid_dst   <= skid_dst_nxt;
    end
  end

endmodule
